hi_reg_term: RTL and testbench

// - Device-side responder on the Host Interface di_* bus: a register-bank terminal answering one terminal address.
// - Sits downstream of the host arbiter / term mux; serves burst writes and prefetched burst reads to NUM_REGS 32-bit regs.
// - Register contents exported flat with per-register write strobes for use by surrounding logic.

---
 rtl/hi_pkg.sv | 25 ++
 rtl/hi_reg_term_bank.sv | 47 ++++
 rtl/hi_reg_term.sv | 156 +++++++++++++++
 tb/tb_hi_reg_term.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_pkg.sv
// Shared definitions for the hi_reg_term register terminal.
// Holds the status bit positions, the FSM encoding and the byte-to-word length helper.
package hi_pkg;

  localparam int HI_ST_RANGE    = 0;
  localparam int HI_ST_OVERRUN  = 1;
  localparam int HI_ST_CONFLICT = 2;
  localparam int HI_ST_ABORT    = 3;

  localparam logic [31:0] HI_RD_POISON = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_FETCH,
    ST_RD_VALID,
    ST_DONE
  } hi_state_e;

  // A partial trailing word still counts as a whole word.
  function automatic logic [31:0] hi_words(input logic [31:0] len);
    return {2'b00, len[31:2]} + {31'd0, |len[1:0]};
  endfunction

endpackage

// File: rtl/hi_reg_term_bank.sv
// Register array for hi_reg_term: one write port with 1-cycle strobes and a registered read mux.
module hi_reg_term_bank
  import hi_pkg::*;
#(
  parameter int NUM_REGS = 16,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     re_i,
  input  logic [AW-1:0]            raddr_i,
  input  logic                     rpoison_i,
  output logic [31:0]              rdata_o,
  output logic [32*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      stb_o
);

  logic [31:0]         mem_q [NUM_REGS];
  logic [31:0]         rdata_q;
  logic [NUM_REGS-1:0] stb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      rdata_q <= '0;
      stb_q   <= '0;
    end else begin
      stb_q <= '0;
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
        stb_q[waddr_i] <= 1'b1;
      end
      if (re_i) rdata_q <= rpoison_i ? HI_RD_POISON : mem_q[raddr_i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[32*g +: 32] = mem_q[g];
  end

  assign rdata_o = rdata_q;
  assign stb_o   = stb_q;

endmodule

// File: rtl/hi_reg_term.sv
// Host Interface register-bank terminal: burst writes and prefetched burst reads on the di_* bus.
// Define HI_REG_TERM_ERRCHK_EN to discard/poison accesses at addr >= NUM_REGS and flag status bit0.
module hi_reg_term
  import hi_pkg::*;
#(
  parameter logic [15:0] TERM_ADDR = 16'h0000,
  parameter int          NUM_REGS  = 16
) (
  input  logic                    ifclk,
  input  logic                    reset,
  input  logic [15:0]             di_term_addr,
  input  logic [31:0]             di_reg_addr,
  input  logic [31:0]             di_len,
  input  logic                    di_write_mode,
  input  logic                    di_write,
  input  logic [31:0]             di_reg_datai,
  output logic                    di_write_rdy,
  input  logic                    di_read_mode,
  input  logic                    di_read_req,
  input  logic                    di_read,
  output logic                    di_read_rdy,
  output logic [31:0]             di_reg_datao,
  output logic [15:0]             di_transfer_status,
  output logic [32*NUM_REGS-1:0]  reg_q,
  output logic [NUM_REGS-1:0]     reg_wr_stb
);

  localparam int AW = $clog2(NUM_REGS);

  hi_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic [15:0] status_q, status_d;

  logic          sel, wmode, rmode;
  logic          wr_acc, rd_load, rd_next, wr_oor, rd_oor;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rdata;

  assign sel   = (di_term_addr == TERM_ADDR);
  assign wmode = sel && di_write_mode;
  assign rmode = sel && di_read_mode;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    status_d = status_q;
    wr_acc   = 1'b0;
    rd_load  = 1'b0;
    rd_next  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wmode || rmode) begin
          addr_d   = di_reg_addr;
          rem_d    = hi_words(di_len);
          status_d = '0;
          status_d[HI_ST_CONFLICT] = wmode && rmode;
          state_d  = wmode ? ST_WR : ST_RD_FETCH;
        end
      end
      ST_WR: begin
        if (!wmode) begin
          state_d = ST_IDLE;
          status_d[HI_ST_ABORT] = 1'b1;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (di_write) begin
          wr_acc = 1'b1;
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - 32'd1;
          if (rem_q == 32'd1) state_d = ST_DONE;
        end
      end
      ST_RD_FETCH: begin
        if (!rmode) begin
          state_d = ST_IDLE;
          status_d[HI_ST_ABORT] = 1'b1;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (di_read_req) begin
          rd_load = 1'b1;
          state_d = ST_RD_VALID;
        end
      end
      ST_RD_VALID: begin
        if (!rmode) begin
          state_d = ST_IDLE;
          status_d[HI_ST_ABORT] = 1'b1;
        end else if (di_read) begin
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_d = ST_DONE;
          end else begin
            // Prefetch the following word so rdy stays high back-to-back.
            rd_load = 1'b1;
            rd_next = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (sel && di_write) status_d[HI_ST_OVERRUN] = 1'b1;
        if (!wmode && !rmode) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef HI_REG_TERM_ERRCHK_EN
    wr_oor = (addr_q >= 32'(NUM_REGS));
    rd_oor = ((addr_q + {31'd0, rd_next}) >= 32'(NUM_REGS));
    if ((wr_acc && wr_oor) || (rd_load && rd_oor)) status_d[HI_ST_RANGE] = 1'b1;
`else
    wr_oor = 1'b0;
    rd_oor = 1'b0;
`endif
  end

  assign rd_idx = addr_q[AW-1:0] + AW'(rd_next);

  always_ff @(posedge ifclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      status_q <= status_d;
    end
  end

  hi_reg_term_bank #(
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk_i     (ifclk),
    .rst_i     (reset),
    .we_i      (wr_acc && !wr_oor),
    .waddr_i   (addr_q[AW-1:0]),
    .wdata_i   (di_reg_datai),
    .re_i      (rd_load),
    .raddr_i   (rd_idx),
    .rpoison_i (rd_oor),
    .rdata_o   (rdata),
    .regs_o    (reg_q),
    .stb_o     (reg_wr_stb)
  );

  assign di_write_rdy       = sel && (state_q == ST_WR) && (rem_q != '0);
  assign di_read_rdy        = sel && (state_q == ST_RD_VALID);
  assign di_reg_datao       = sel ? rdata : '0;
  assign di_transfer_status = sel ? status_q : '0;

endmodule

// File: tb/tb_hi_reg_term.sv
// Scoreboard bench for hi_reg_term: randomized bursts against an array model of the register bank.
module tb_hi_reg_term;

  localparam logic [15:0] TA = 16'h0000;
  localparam int          NR = 16;
`ifdef HI_REG_TERM_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic              ifclk = 1'b0;
  logic              reset;
  logic [15:0]       di_term_addr;
  logic [31:0]       di_reg_addr, di_len, di_reg_datai, di_reg_datao;
  logic              di_write_mode, di_write, di_write_rdy;
  logic              di_read_mode, di_read_req, di_read, di_read_rdy;
  logic [15:0]       di_transfer_status;
  logic [32*NR-1:0]  reg_q;
  logic [NR-1:0]     reg_wr_stb;

  always #5 ifclk = ~ifclk;

  hi_reg_term #(.TERM_ADDR(TA), .NUM_REGS(NR)) dut (
    .ifclk(ifclk), .reset(reset), .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_len(di_len), .di_write_mode(di_write_mode), .di_write(di_write),
    .di_reg_datai(di_reg_datai), .di_write_rdy(di_write_rdy), .di_read_mode(di_read_mode),
    .di_read_req(di_read_req), .di_read(di_read), .di_read_rdy(di_read_rdy),
    .di_reg_datao(di_reg_datao), .di_transfer_status(di_transfer_status),
    .reg_q(reg_q), .reg_wr_stb(reg_wr_stb)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [NR];
  logic [31:0] exp_rd_q [$];
  int          exp_wr_idx_q [$];
  logic [31:0] exp_wr_dat_q [$];
  logic [31:0] wdata_src_q [$];

  task automatic check(input string name, input logic [32*NR-1:0] act, input logic [32*NR-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUT presents a read word or a write strobe.
  logic [31:0]   mon_d;
  int            mon_i;
  logic [NR-1:0] mon_s;
  always @(negedge ifclk) begin
    if (!reset) begin
      if (di_read_rdy && di_read) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected got=%0h expected=none", di_reg_datao);
        end else begin
          mon_d = exp_rd_q.pop_front();
          check("rd_data", di_reg_datao, mon_d);
        end
      end
      if (reg_wr_stb != '0) begin
        if (exp_wr_idx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_stb_unexpected got=%0h expected=0", reg_wr_stb);
        end else begin
          mon_i = exp_wr_idx_q.pop_front();
          mon_d = exp_wr_dat_q.pop_front();
          mon_s = '0;
          mon_s[mon_i] = 1'b1;
          check("wr_stb", reg_wr_stb, mon_s);
          check("wr_data", reg_q[32*mon_i +: 32], mon_d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  function automatic int words_of(input logic [31:0] len);
    return int'(len >> 2) + ((len % 4) != 0 ? 1 : 0);
  endfunction

  task automatic compare_regs(input string name);
    logic [32*NR-1:0] flat;
    for (int i = 0; i < NR; i++) flat[32*i +: 32] = model_regs[i];
    check(name, reg_q, flat);
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [31:0] len, input int npulse,
                          input int stop_after, input bit both_modes);
    int          words, sent;
    logic [31:0] d, wa;
    logic [15:0] exp_st;
    words  = words_of(len);
    sent   = 0;
    exp_st = both_modes ? 16'h0004 : 16'h0000;
    di_reg_addr = a; di_len = len; di_write_mode = 1'b1; di_read_mode = both_modes;
    tick();
    for (int p = 0; p < npulse; p++) begin
      if (p == stop_after) break;
      if ($urandom_range(0, 3) == 0) begin
        di_write = 1'b0;
        tick();
      end
      check("wr_rdy", di_write_rdy, p < words);
      if (wdata_src_q.size() > 0) d = wdata_src_q.pop_front();
      else d = $urandom();
      di_write = 1'b1; di_reg_datai = d;
      if (p < words) begin
        wa = a + p;
        if (ERRCHK && wa >= NR) exp_st[0] = 1'b1;
        else begin
          model_regs[wa % NR] = d;
          exp_wr_idx_q.push_back(int'(wa % NR));
          exp_wr_dat_q.push_back(d);
        end
      end else begin
        exp_st[1] = 1'b1;
      end
      sent++;
      tick();
    end
    if (sent < words) begin
      exp_st[3] = 1'b1;
      di_write = 1'b1; di_reg_datai = $urandom();
    end else begin
      di_write = 1'b0;
      check("wr_rdy_end", di_write_rdy, 0);
    end
    di_write_mode = 1'b0; di_read_mode = 1'b0;
    tick();
    di_write = 1'b0;
    check("wr_status", di_transfer_status, exp_st);
    check("wr_rdy_idle", di_write_rdy, 0);
    check("wr_q_empty", exp_wr_idx_q.size(), 0);
    compare_regs("wr_regs");
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [31:0] len, input bit gaps, input int reset_after);
    int          words;
    logic [31:0] ra;
    logic [15:0] exp_st;
    words  = words_of(len);
    exp_st = '0;
    di_reg_addr = a; di_len = len; di_read_mode = 1'b1;
    tick();
    if (words == 0) begin
      check("rd0_rdy_a", di_read_rdy, 0);
      tick();
      check("rd0_rdy_b", di_read_rdy, 0);
    end else begin
      repeat ($urandom_range(0, 2)) begin
        di_read = 1'($urandom_range(0, 1));
        tick();
        check("rd_rdy_wait", di_read_rdy, 0);
      end
      di_read = 1'b0; di_read_req = 1'b1;
      tick();
      di_read_req = 1'b0;
      check("rd_rdy_lat", di_read_rdy, 1);
      for (int w = 0; w < words; w++) begin
        ra = a + w;
        if (ERRCHK && ra >= NR) begin
          exp_st[0] = 1'b1;
          exp_rd_q.push_back(32'hDEAD_BEEF);
        end else begin
          exp_rd_q.push_back(model_regs[ra % NR]);
        end
      end
      for (int w = 0; w < words; w++) begin
        if (w == reset_after) begin
          di_read = 1'b0; di_read_mode = 1'b0; reset = 1'b1;
          exp_rd_q.delete();
          for (int i = 0; i < NR; i++) model_regs[i] = '0;
          tick();
          reset = 1'b0;
          check("rst_rdy", di_read_rdy, 0);
          check("rst_datao", di_reg_datao, 0);
          check("rst_status", di_transfer_status, 0);
          compare_regs("rst_regs");
          return;
        end
        if (gaps && $urandom_range(0, 2) == 0) begin
          di_read = 1'b0;
          tick();
        end
        check("rd_rdy_b2b", di_read_rdy, 1);
        di_read = 1'b1;
        tick();
      end
      di_read = 1'b0;
      check("rd_rdy_end", di_read_rdy, 0);
    end
    di_read_mode = 1'b0;
    tick();
    check("rd_status", di_transfer_status, exp_st);
    check("rd_q_empty", exp_rd_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; di_term_addr = TA; di_reg_addr = '0; di_len = '0; di_write_mode = 1'b0;
    di_write = 1'b0; di_reg_datai = '0; di_read_mode = 1'b0; di_read_req = 1'b0; di_read = 1'b0;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    repeat (2) tick();
    reset = 1'b0;
    check("reset_regs", reg_q, 0);
    check("reset_outs", {di_write_rdy, di_read_rdy, di_reg_datao, di_transfer_status, reg_wr_stb}, 0);

    wdata_src_q = '{32'h11, 32'h22, 32'h33};
    wr_burst(32'd2, 32'd12, 3, -1, 1'b0);
    wdata_src_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    wr_burst(32'd0, 32'd16, 4, -1, 1'b0);
    rd_burst(32'd0, 32'd16, 1'b0, -1);
    wdata_src_q = '{32'h5, 32'h6};
    wr_burst(32'd15, 32'd8, 2, -1, 1'b0);
    wr_burst(32'd7, 32'd4, 2, -1, 1'b0);
    wr_burst(32'd8, 32'd16, 4, 2, 1'b0);
    wr_burst(32'd3, 32'd4, 1, -1, 1'b1);
    wr_burst(32'd5, 32'd6, 2, -1, 1'b0);
    rd_burst(32'd14, 32'd16, 1'b1, -1);
    rd_burst(32'd1, 32'd0, 1'b0, -1);

    // Another terminal selected: nothing may change and every di_* output stays 0.
    di_term_addr = TA + 16'd1; di_reg_addr = 32'd1; di_len = 32'd8; di_write_mode = 1'b1;
    repeat (4) begin
      di_write = 1'b1; di_reg_datai = $urandom();
      tick();
      check("nosel_outs", {di_write_rdy, di_read_rdy, di_reg_datao, di_transfer_status}, 0);
    end
    di_write = 1'b0; di_write_mode = 1'b0; di_term_addr = TA;
    tick();
    compare_regs("nosel_regs");

    for (int it = 0; it < 40; it++) begin
      logic [31:0] a, len;
      int w, np, st;
      a   = $urandom_range(0, NR - 1);
      len = $urandom_range(1, 40);
      w   = words_of(len);
      if ($urandom_range(0, 1) == 1) begin
        np = $urandom_range(1, w + 1);
        st = ($urandom_range(0, 4) == 0) ? $urandom_range(0, np - 1) : -1;
        wr_burst(a, len, np, st, 1'($urandom_range(0, 7) == 0));
      end else begin
        rd_burst(a, len, 1'b1, -1);
      end
    end

    wr_burst(32'd0, 32'd16, 4, -1, 1'b0);
    rd_burst(32'd0, 32'd16, 1'b0, 2);
    tick();
    compare_regs("final_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
